outport_arbiter: RTL and testbench
==================================

OUTPORT_ARBITER -- requirements
Module: outport_arbiter

Interface
REQ-001 Parameter no_inport, default 6, number of requesting input ports sharing this output port.
REQ-002 Parameter timeout_cycles, default 255, maximum GRANT-state cycles before forced release; 0 disables the watchdog.
REQ-003 Parameter cnt_width, default 8, watchdog counter width; timeout_cycles SHALL fit in cnt_width bits.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rs  input  1  reset, asynchronous, active-low.
REQ-006 reqs  input  no_inport  per-inport request for this output port; level, held by requester until served.
REQ-007 release_sig  input  1  end-of-packet from the output multiplexer; 1-cycle pulse.
REQ-008 select  output  no_inport  one-hot grant vector driving the multiplexer select; registered.
REQ-009 en  output  1  multiplexer enable; registered.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 timeout  output  1  1-cycle pulse on watchdog-forced release.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT, and DRAIN, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next edge with select=0 and en=0.
REQ-013 IDLE: select=0, en=0; if reqs!=0, latch winner, go to GRANT; otherwise stay.
REQ-014 Arbitration is round-robin: winner = first index i with reqs[i]=1 searching ptr, ptr+1, ..., wrapping modulo no_inport.
REQ-015 Latency: reqs sampled high at edge N -> select one-hot and en=1 visible after edge N (GRANT entered at edge N).
REQ-016 GRANT: select and en=1 held constant; changes in reqs (including holder deasserting) SHALL NOT alter select.
REQ-017 GRANT: watchdog counter increments each cycle from 0; cleared on GRANT entry.
REQ-018 GRANT + release_sig=1: next edge en=0, ptr = (winner+1) mod no_inport, enter DRAIN.
REQ-019 GRANT + timeout_cycles!=0 + counter==timeout_cycles-1 and release_sig=0: same transition as REQ-018, timeout=1 for exactly one cycle.
REQ-020 Simultaneous release_sig and watchdog expiry: treated as normal release, timeout stays 0.
REQ-021 DRAIN: en=0, select held for exactly 2 cycles (covers the multiplexer's 2-stage select/enable pipeline), then select=0 and enter IDLE.
REQ-022 release_sig in IDLE or DRAIN SHALL be ignored.
REQ-023 Minimum back-to-back grant spacing: 3 cycles of en=0 between consecutive grants (2 DRAIN + 1 IDLE).
REQ-024 ptr SHALL wrap from no_inport-1 to 0; ptr is log2-ceiling(no_inport) bits, never holding values >= no_inport.
REQ-025 select SHALL be one-hot or zero at all times; en=1 implies select!=0.

Reset
REQ-026 rs=0 SHALL immediately, independent of clk: state=IDLE, select=0, en=0, busy=0, timeout=0, ptr=0, watchdog=0.
REQ-027 Reset asserted mid-GRANT or mid-DRAIN SHALL abort without a timeout pulse; after rs rises, first arbitration starts at ptr=0.
REQ-028 Outputs SHALL stay at reset values while rs=0 regardless of reqs.

Verification
REQ-029 reqs=6'b000100 from idle after reset -> next edge select=000100, en=1, busy=1; release_sig pulse -> en=0 next edge, select=000100 two more cycles, then 0.
REQ-030 reqs=6'b111111 held, release after each grant -> grant order 0,1,2,3,4,5,0 with 3 idle en cycles between grants.
REQ-031 ptr=5 after inport 4 served, reqs=6'b010001 -> inport 0 granted (wrap), then inport 4.
REQ-032 timeout_cycles=4, no release -> en high exactly 4 cycles, timeout pulses 1 cycle, DRAIN follows; release coincident with 4th cycle -> no timeout pulse.
REQ-033 rs driven low between clock edges during GRANT -> select=0, en=0 immediately; after release, reqs=6'b100001 grants inport 0.
REQ-034 Holder drops reqs mid-GRANT, another inport raises reqs -> select unchanged until release_sig.

Source files
------------

// File: rtl/outport_arbiter.sv
// Round-robin arbiter for one output port: grants a single requesting inport,
// holds the grant until end-of-packet or watchdog expiry, then drains the mux pipeline.
module outport_arbiter #(
  parameter int no_inport      = 6,
  parameter int timeout_cycles = 255,
  parameter int cnt_width      = 8
) (
  input  logic                 clk,
  input  logic                 rs,
  input  logic [no_inport-1:0] reqs,
  input  logic                 release_sig,
  output logic [no_inport-1:0] select,
  output logic                 en,
  output logic                 busy,
  output logic                 timeout
);

  localparam int PW = (no_inport > 1) ? $clog2(no_inport) : 1;
  localparam logic [cnt_width-1:0] WD_LAST  = cnt_width'(timeout_cycles - 1);
  localparam logic [PW-1:0]        LAST_IDX = PW'(no_inport - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [no_inport-1:0]   r_select, w_select_nxt, w_onehot;
  logic                   r_en, w_en_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic [PW-1:0]          r_ptr, r_win, w_win;
  logic [cnt_width-1:0]   r_wdog;
  logic                   r_drain;
  logic                   w_found, w_expire, w_end;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(no_inport)) s = s - 32'(no_inport);
    return PW'(s);
  endfunction

  // First requester at or after ptr, wrapping modulo no_inport.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    for (int unsigned k = 0; k < no_inport; k++) begin
      if (!w_found && reqs[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, k);
      end
    end
    w_onehot = '0;
    if (w_found) w_onehot[w_win] = 1'b1;
  end

  assign w_expire = (timeout_cycles != 0) && (r_wdog == WD_LAST);
  assign w_end    = release_sig || w_expire;

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_found ? S_GRANT : S_IDLE;
      S_GRANT: w_state_nxt = w_end ? S_DRAIN : S_GRANT;
      S_DRAIN: w_state_nxt = r_drain ? S_IDLE : S_DRAIN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; release wins over a coincident expiry.
  always_comb begin
    w_select_nxt  = r_select;
    w_en_nxt      = r_en;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_select_nxt = w_found ? w_onehot : '0;
        w_en_nxt     = w_found;
      end
      S_GRANT: begin
        if (w_end) begin
          w_en_nxt      = 1'b0;
          w_timeout_nxt = w_expire && !release_sig;
        end
      end
      S_DRAIN: begin
        w_en_nxt = 1'b0;
        if (r_drain) w_select_nxt = '0;
      end
      default: begin
        w_select_nxt = '0;
        w_en_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_state   <= S_IDLE;
      r_select  <= '0;
      r_en      <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_win     <= '0;
      r_wdog    <= '0;
      r_drain   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_select  <= w_select_nxt;
      r_en      <= w_en_nxt;
      r_timeout <= w_timeout_nxt;
      case (r_state)
        S_IDLE: begin
          r_wdog  <= '0;
          r_drain <= 1'b0;
          if (w_found) r_win <= w_win;
        end
        S_GRANT: begin
          r_wdog  <= r_wdog + 1'b1;
          r_drain <= 1'b0;
          if (w_end) r_ptr <= (r_win == LAST_IDX) ? '0 : r_win + PW'(1);
        end
        S_DRAIN: r_drain <= 1'b1;
        default: begin
          r_wdog  <= '0;
          r_drain <= 1'b0;
        end
      endcase
    end
  end

  assign select  = r_select;
  assign en      = r_en;
  assign busy    = (r_state != S_IDLE);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_outport_arbiter.sv
// Directed bench for outport_arbiter: expected grants queued at stimulus time,
// compared when en rises; latency, drain, watchdog and reset checked inline.
module tb_outport_arbiter;

  localparam int N = 6;

  logic         clk;
  logic         rs;
  logic         release_sig;
  logic [N-1:0] reqs;
  logic [N-1:0] select;
  logic         en;
  logic         busy;
  logic         timeout;

  int           checks   = 0;
  int           failures = 0;
  logic [N-1:0] sb_q[$];
  logic         prev_en  = 1'b0;

  outport_arbiter #(
    .no_inport      (N),
    .timeout_cycles (4),
    .cnt_width      (8)
  ) dut (
    .clk         (clk),
    .rs          (rs),
    .reqs        (reqs),
    .release_sig (release_sig),
    .select      (select),
    .en          (en),
    .busy        (busy),
    .timeout     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scoreboard consumer plus per-cycle output invariants.
  always @(negedge clk) begin
    logic [N-1:0] e;
    chk("onehot0", 32'($onehot0(select)), 1);
    chk("en_implies_sel", 32'(!en || (select != '0)), 1);
    if (en && !prev_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_grant", 32'(select), 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_grant", 32'(select), 32'(e));
      end
    end
    prev_en = en;
  end

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!en && lat < 20);
    chk("grant_seen", 32'(en), 1);
  endtask

  task automatic rel();
    release_sig = 1'b1;
    @(negedge clk);
    release_sig = 1'b0;
    chk("rel_en_low", 32'(en), 0);
    chk("rel_no_timeout", 32'(timeout), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    int lat;
    int n;
    rs          = 1'b0;
    reqs        = '1;
    release_sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_select", 32'(select), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reqs = '0;
    rs   = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);

    // All inports requesting: strict rotation starting from ptr=0.
    reqs = '1;
    for (int g = 0; g < 7; g++) sb_q.push_back(oh(g % N));
    for (int g = 0; g < 7; g++) begin
      wait_grant(lat);
      chk("rr_latency", 32'(lat), (g == 0) ? 32'd1 : 32'd3);
      if (g == 6) begin
        reqs = 6'b010000;
        sb_q.push_back(oh(4));
      end
      rel();
    end

    // Wrap: inport 4 served leaves ptr=5, so inport 0 beats inport 4.
    wait_grant(lat);
    chk("gap_to_4", 32'(lat), 3);
    reqs = 6'b010001;
    sb_q.push_back(oh(0));
    rel();
    wait_grant(lat);
    chk("wrap_gap", 32'(lat), 3);
    reqs = 6'b010000;
    sb_q.push_back(oh(4));
    rel();
    wait_grant(lat);
    reqs = '0;
    rel();
    wait_idle();

    // Single request, release, then two held select cycles; stray releases ignored.
    reqs = 6'b000100;
    sb_q.push_back(oh(2));
    @(negedge clk);
    chk("single_en", 32'(en), 1);
    chk("single_sel", 32'(select), 32'(oh(2)));
    chk("single_busy", 32'(busy), 1);
    reqs        = '0;
    release_sig = 1'b1;
    @(negedge clk);
    chk("drain1_en", 32'(en), 0);
    chk("drain1_sel", 32'(select), 32'(oh(2)));
    release_sig = 1'b1;
    @(negedge clk);
    release_sig = 1'b0;
    chk("drain2_sel", 32'(select), 32'(oh(2)));
    chk("drain2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("drain_done_sel", 32'(select), 0);
    chk("drain_done_busy", 32'(busy), 0);
    release_sig = 1'b1;
    @(negedge clk);
    release_sig = 1'b0;
    chk("idle_rel_ignored", 32'(busy), 0);

    // Watchdog: four en cycles then a single timeout pulse.
    reqs = 6'b000010;
    sb_q.push_back(oh(1));
    wait_grant(lat);
    reqs = '0;
    n    = 1;
    while (n < 20) begin
      @(negedge clk);
      if (!en) break;
      n++;
    end
    chk("wd_en_cycles", 32'(n), 4);
    chk("wd_pulse", 32'(timeout), 1);
    chk("wd_sel_held", 32'(select), 32'(oh(1)));
    @(negedge clk);
    chk("wd_pulse_end", 32'(timeout), 0);
    wait_idle();

    // Release coincident with expiry counts as a normal release.
    reqs = 6'b000010;
    sb_q.push_back(oh(1));
    wait_grant(lat);
    reqs = '0;
    repeat (3) @(negedge clk);
    chk("wd_4th_cycle_en", 32'(en), 1);
    rel();
    wait_idle();

    // Asynchronous reset mid-GRANT, then arbitration restarts at ptr=0.
    reqs = 6'b001000;
    sb_q.push_back(oh(3));
    wait_grant(lat);
    reqs = '0;
    #2 rs = 1'b0;
    #1;
    chk("async_rst_sel", 32'(select), 0);
    chk("async_rst_en", 32'(en), 0);
    chk("async_rst_busy", 32'(busy), 0);
    reqs = '1;
    @(negedge clk);
    chk("rst_hold_sel", 32'(select), 0);
    chk("rst_hold_timeout", 32'(timeout), 0);
    reqs = 6'b100001;
    rs   = 1'b1;
    sb_q.push_back(oh(0));
    wait_grant(lat);
    chk("post_rst_latency", 32'(lat), 1);

    // Holder drops while another raises: grant is not disturbed.
    reqs = 6'b000100;
    sb_q.push_back(oh(2));
    repeat (2) begin
      @(negedge clk);
      chk("hold_sel", 32'(select), 32'(oh(0)));
      chk("hold_en", 32'(en), 1);
    end
    rel();
    wait_grant(lat);
    chk("hold_next_gap", 32'(lat), 3);
    reqs = '0;
    rel();
    wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
